// File: rtl/latch_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : latch_seq_pkg
//  Description : Shared types and defaults for the latch bank sequencer.
//                Sequencer states, default parameter values and the state
//                and strobe-counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package latch_seq_pkg;

    localparam int DEFAULT_N_REQ         = 4;
    localparam int DEFAULT_WIDTH         = 8;
    localparam int DEFAULT_STROBE_CYCLES = 1;

    localparam int STATE_W = 3;
    // Strobe length is 1..15, so a 4-bit down-counter covers it.
    localparam int CNT_W   = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/latch_bank_sequencer_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Selects the first
//                requesting index at or above ptr_i, wrapping at N_REQ.
//                The pointer itself lives in the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import latch_seq_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;
    int   j;

    // Scan from the pointer upward with wrap; first requester wins.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!found && req_i[j[IDX_W-1:0]]) begin
                found = 1'b1;
                idx_o = j[IDX_W-1:0];
            end
        end
        if (found) begin
            pick_o[idx_o] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/latch_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : latch_bank_sequencer
//  Description : Round-robin write sequencer for a bank of level-sensitive
//                latches. Drives latch D/EN through setup, strobe and
//                (optional) hold phases so D is stable whenever EN is high.
//                Build option: define HOLD_PHASE_EN to insert a one-cycle
//                HOLD phase between STROBE and DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_bank_sequencer
    import latch_seq_pkg::*;
#(
    parameter int N_REQ         = DEFAULT_N_REQ,
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int STROBE_CYCLES = DEFAULT_STROBE_CYCLES
)(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*WIDTH-1:0] din_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       ack_o,
    output logic [WIDTH-1:0]       lat_d_o,
    output logic                   lat_en_o,
    output logic                   busy_o
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t             state_q,  state_d;
    logic [N_REQ-1:0]   gnt_q,    gnt_d;
    logic [IDX_W-1:0]   gidx_q,   gidx_d;
    logic [IDX_W-1:0]   ptr_q,    ptr_d;
    logic [WIDTH-1:0]   lat_d_q,  lat_d_d;
    logic               lat_en_q, lat_en_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic [N_REQ-1:0]   w_pick;
    logic [IDX_W-1:0]   w_idx;
    logic [WIDTH-1:0]   w_din_sel;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i  (req_i),
        .ptr_i  (ptr_q),
        .pick_o (w_pick),
        .idx_o  (w_idx)
    );

    // Route the winning requester's data slice toward the LAT_D register.
    always_comb begin
        w_din_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick[i]) begin
                w_din_sel = din_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic: grant in IDLE, then walk setup/strobe/hold/done.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        lat_d_d = lat_d_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = w_pick;
                    gidx_d  = w_idx;
                    lat_d_d = w_din_sel;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_W'(STROBE_CYCLES - 1);
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == '0) begin
`ifdef HOLD_PHASE_EN
                    state_d = HOLD;
`else
                    state_d = DONE;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef HOLD_PHASE_EN
            HOLD: begin
                state_d = DONE;
            end
`endif
            DONE: begin
                // Next search starts just past the requester that was served.
                ptr_d   = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // EN is registered from the upcoming state, so it is glitch-free.
        lat_en_d = (state_d == STROBE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            lat_d_q  <= '0;
            lat_en_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign ack_o    = (state_q == DONE) ? gnt_q : '0;
    assign lat_d_o  = lat_d_q;
    assign lat_en_o = lat_en_q;
    assign busy_o   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/latch_bank_sequencer.md
# latch_bank_sequencer

Round-robin write sequencer for a shared bank of level-sensitive D-latches. Up to N_REQ requesters post write requests; the block grants one at a time and drives the latch data and enable lines through a fixed setup / strobe / hold sequence, so D never changes while EN is high. It sits between requester logic and the latch bank and is the only driver of that bank's EN and D inputs.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, latch data width
- STROBE_CYCLES, 1, cycles LAT_EN stays high (1..15)

- CLK  in  1  single clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- REQ  in  N_REQ  per-requester write request, level
- DIN  in  N_REQ*WIDTH  per-requester data; slice i = DIN[i*WIDTH +: WIDTH]
- GNT  out  N_REQ  one-hot grant, high from grant through ACK
- ACK  out  N_REQ  one-cycle pulse to the granted requester when its write completes
- LAT_D  out  WIDTH  data to latch bank D
- LAT_EN  out  1  latch bank EN
- BUSY  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: if any REQ bit is high, the round-robin arbiter picks the first requesting index at or above PTR (wrapping). On the edge: GNT one-hot set, LAT_D <= selected DIN slice, state -> SETUP. No REQ: stay IDLE.
- SETUP: LAT_EN=0, LAT_D stable. -> STROBE.
- STROBE: LAT_EN=1 for exactly STROBE_CYCLES cycles (down-counter), LAT_D stable. -> HOLD (or DONE, see Configuration).
- HOLD: LAT_EN=0, LAT_D stable. -> DONE.
- DONE: ACK[g]=1 for this cycle only; PTR <= (g+1) mod N_REQ. -> IDLE; GNT cleared on the same edge.
- DIN is captured at grant; the requester need not hold DIN afterwards. LAT_D keeps its last value in IDLE.
- A requester keeps REQ high until it sees ACK. REQ still high in the cycle after ACK counts as a new request and competes normally, so it cannot starve others.
- REQ dropping after grant does not abort; the write completes and ACK is still issued.
- Sampled REQ bits are only evaluated in IDLE; changes during a transaction are ignored until IDLE.
- Reset values: GNT=0, ACK=0, LAT_D=0, LAT_EN=0, BUSY=0, PTR=0, state=IDLE.

## Timing
- Let grant edge = edge E at end of the IDLE cycle with REQ high.
- With hold phase: SETUP cycle E+1, STROBE cycles E+2..E+1+S, HOLD E+2+S, ACK in cycle E+3+S. Transaction occupancy S+3 cycles. Next grant possible at edge ending cycle E+4+S.
- Without hold phase: ACK in cycle E+2+S, occupancy S+2.
- LAT_EN is a registered output, glitch-free. LAT_D never changes in a cycle adjacent to LAT_EN high.
- RST_N low at any edge: all outputs and PTR take reset values on that edge. An in-flight write is abandoned with no ACK. LAT_EN falls on that edge.

## Configuration
- HOLD_PHASE_EN defined: HOLD state present, timing as above.
- Not defined: STROBE transitions directly to DONE. LAT_D still stays stable through DONE and does not change until the next grant.

## Structure
- Package latch_seq_pkg: state enum (IDLE, SETUP, STROBE, HOLD, DONE), default N_REQ/WIDTH/STROBE_CYCLES constants, state-width constant.
- Sub-module rr_arbiter: inputs REQ and PTR, output one-hot pick and encoded index. Purely combinational; PTR is owned by the sequencer.
- The top level holds the FSM, strobe counter, PTR, and output registers.

## Test plan
- Reset then single REQ[2]=1, DIN slice2=8'hA5, S=1, HOLD_PHASE_EN on -> GNT=4'b0100 from E, LAT_D=8'hA5 at E+1, LAT_EN high only in cycle E+2, ACK[2] only in cycle E+4.
- REQ=4'b1111 held constantly -> grants cycle 0,1,2,3,0 with PTR wrap. Each ACK is separated by S+4 cycles.
- S=3 -> LAT_EN high exactly 3 consecutive cycles. LAT_D is unchanged one cycle before and after that window.
- HOLD_PHASE_EN undefined, S=1 -> ACK in cycle E+3 and no LAT_EN-low cycle between STROBE and DONE.
- REQ[1] dropped after grant -> ACK[1] still pulses. Other REQ changes during the transaction are ignored until IDLE.
- RST_N low during STROBE -> on that edge LAT_EN=0, GNT=0, BUSY=0. No ACK follows, and PTR=0 afterwards.
